// File: rtl/mult_seq_pkg.sv
// Shared definitions for the multiplier sequencer.
// Holds the FSM state encoding and the default operand width.
package mult_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        WAIT   = 3'd2,
        OUT_LO = 3'd3,
        OUT_HI = 3'd4
    } state_t;

endpackage

// File: rtl/mult_seq_lat_cnt.sv
// Loadable down-counter that times the multiplier latency window.
// Latency: done is combinational from the count; load takes effect on the next edge.
// Backpressure: none, the counter free-runs down to zero and holds there.
module mult_seq_lat_cnt #(
    parameter int MUL_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(MUL_LAT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(MUL_LAT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shared multiplier: takes A then B bytes, waits MUL_LAT cycles, returns the product low byte first.
// Latency: 4 + MUL_LAT cycles per product back to back. Optional accumulate mode under MULT_SEQ_MAC_EN.
// Backpressure: in_ready only in LOAD_A/LOAD_B; result bytes held stable while out_ready is low.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               acc_clr,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_hi,
    output logic               busy
);

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] result;
    logic [2*WIDTH-1:0] result_nxt;
    logic               a_acc, b_acc, cap, lat_done;

    assign a_acc = (state == LOAD_A) && in_valid;
    assign b_acc = (state == LOAD_B) && in_valid;
    assign cap   = (state == WAIT) && lat_done;

    mult_seq_lat_cnt #(
        .MUL_LAT (MUL_LAT)
    ) u_lat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (b_acc),
        .done (lat_done)
    );

`ifdef MULT_SEQ_MAC_EN
    logic acc_clr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_clr_q <= 1'b0;
        end else if (a_acc) begin
            acc_clr_q <= acc_clr;
        end
    end

    // Accumulation wraps silently at 2*WIDTH bits.
    assign result_nxt = acc_clr_q ? mul_p : result + mul_p;
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
    assign result_nxt     = mul_p;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LOAD_A;
            mul_a  <= '0;
            mul_b  <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (a_acc) mul_a <= in_data;
            if (b_acc) mul_b <= in_data;
            if (cap)   result <= result_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_hi    = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        case (state)
            LOAD_A: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_done) state_nxt = OUT_LO;
            end
            OUT_LO: begin
                out_valid = 1'b1;
                out_data  = result[WIDTH-1:0];
                if (out_ready) state_nxt = OUT_HI;
            end
            OUT_HI: begin
                out_valid = 1'b1;
                out_hi    = 1'b1;
                out_data  = result[2*WIDTH-1:WIDTH];
                if (out_ready) state_nxt = LOAD_A;
            end
            default: state_nxt = LOAD_A;
        endcase
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: instance 0 runs with MUL_LAT=2, instance 1 with MUL_LAT=1.
// Expected bytes are queued at issue time and popped by a free-running output monitor.
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]       in_valid, in_ready, acc_clr, out_valid, out_ready, out_hi, busy;
    logic [1:0][7:0]  in_data, mul_a, mul_b, out_data;
    logic [1:0][15:0] mul_p;
    logic [15:0]      mp0_q;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    int          t0[$];
    int          t1[$];
    logic [15:0] acc_m [2];

    mult_seq_ctrl #(.WIDTH(8), .MUL_LAT(2)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .acc_clr(acc_clr[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mul_p[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_hi(out_hi[0]), .busy(busy[0])
    );

    mult_seq_ctrl #(.WIDTH(8), .MUL_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .acc_clr(acc_clr[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mul_p[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_hi(out_hi[1]), .busy(busy[1])
    );

    // Multiplier models: one register stage for MUL_LAT=2, purely combinational for MUL_LAT=1.
    always @(posedge clk) mp0_q <= 16'(mul_a[0]) * 16'(mul_b[0]);
    assign mul_p[0] = mp0_q;
    assign mul_p[1] = 16'(mul_a[1]) * 16'(mul_b[1]);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic mon(input int i);
        logic [8:0] e;
        if (rst || !out_valid[i]) return;
        if (qsize(i) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out inst=%0d actual=0x%0h required=no_output", i, out_data[i]);
            return;
        end
        e = (i == 0) ? q0[0] : q1[0];
        chk($sformatf("out_data inst=%0d", i), 32'(out_data[i]), 32'(e[7:0]));
        chk($sformatf("out_hi inst=%0d", i), 32'(out_hi[i]), 32'(e[8]));
        chk($sformatf("in_ready_in_out inst=%0d", i), 32'(in_ready[i]), 32'd0);
        if (out_ready[i]) begin
            if (i == 0) begin
                void'(q0.pop_front());
                if (!e[8]) t0.push_back(cyc);
            end else begin
                void'(q1.pop_front());
                if (!e[8]) t1.push_back(cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Present one beat and return just after the edge that accepts it; in_valid is left high.
    task automatic beat(input int i, input logic [7:0] d, input logic clr);
        int n = 0;
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        acc_clr[i]  = clr;
        @(negedge clk);
        while (!in_ready[i] && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) fail_now($sformatf("accept_timeout inst=%0d", i));
        @(posedge clk);
        #1;
    endtask

    task automatic prod(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic clr, input logic expect_out);
        logic [15:0] p;
        beat(i, a, clr);
        if (expect_out) begin
            p = 16'(a) * 16'(b);
`ifdef MULT_SEQ_MAC_EN
            acc_m[i] = clr ? p : acc_m[i] + p;
`else
            acc_m[i] = p;
`endif
            if (i == 0) begin
                q0.push_back({1'b0, acc_m[i][7:0]});
                q0.push_back({1'b1, acc_m[i][15:8]});
            end else begin
                q1.push_back({1'b0, acc_m[i][7:0]});
                q1.push_back({1'b1, acc_m[i][15:8]});
            end
        end
        beat(i, b, clr);
    endtask

    task automatic drain(input int i);
        int n = 0;
        while (qsize(i) != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) fail_now($sformatf("drain_timeout inst=%0d", i));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        acc_clr   = '0;
        out_ready = 2'b11;
        acc_m[0]  = '0;
        acc_m[1]  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_in_ready inst=%0d", i), 32'(in_ready[i]), 32'd1);
            chk($sformatf("rst_out_valid inst=%0d", i), 32'(out_valid[i]), 32'd0);
            chk($sformatf("rst_mul_a inst=%0d", i), 32'(mul_a[i]), 32'd0);
            chk($sformatf("rst_mul_b inst=%0d", i), 32'(mul_b[i]), 32'd0);
            chk($sformatf("rst_out_data inst=%0d", i), 32'(out_data[i]), 32'd0);
            chk($sformatf("rst_out_hi inst=%0d", i), 32'(out_hi[i]), 32'd0);
            chk($sformatf("rst_busy inst=%0d", i), 32'(busy[i]), 32'd0);
        end
        @(posedge clk);
        #1;

        // 0x0F * 0x11 = 0x00FF, WAIT is exactly MUL_LAT=2 cycles.
        prod(0, 8'h0F, 8'h11, 1'b1, 1'b1);
        in_valid[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid[0] && n < 50) begin
            chk("busy_in_wait", 32'(busy[0]), 32'd1);
            n++;
            @(negedge clk);
        end
        chk("wait_len", 32'(n), 32'd2);
        drain(0);

        // 0xFF * 0xFF = 0xFE01 with the low byte stalled for 5 cycles.
        out_ready[0] = 1'b0;
        prod(0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        in_valid[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid[0] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) fail_now("stall_out_valid");
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        drain(0);

        // Reset during WAIT discards the operation.
        prod(0, 8'h07, 8'h09, 1'b1, 1'b0);
        in_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        acc_m[0] = '0;
        acc_m[1] = '0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("midrst_mul_a", 32'(mul_a[0]), 32'd0);
        chk("midrst_mul_b", 32'(mul_b[0]), 32'd0);
        chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1;
        prod(0, 8'h03, 8'h04, 1'b1, 1'b1);
        in_valid[0] = 1'b0;
        drain(0);

        // Streaming 2,3,4,5 with in_valid held: 0x0006 then 0x0014, 6 cycles apart.
        t0.delete();
        prod(0, 8'h02, 8'h03, 1'b1, 1'b1);
        prod(0, 8'h04, 8'h05, 1'b1, 1'b1);
        in_valid[0] = 1'b0;
        drain(0);
        chk("stream_count_l2", 32'(t0.size()), 32'd2);
        if (t0.size() == 2) chk("stream_period_l2", 32'(t0[1] - t0[0]), 32'd6);

`ifdef MULT_SEQ_MAC_EN
        // 0x000C, 0x000C+0x001E=0x002A, 0xFE01, 0xFE01+0xFE01 wraps to 0xFC02.
        prod(0, 8'h03, 8'h04, 1'b1, 1'b1);
        prod(0, 8'h05, 8'h06, 1'b0, 1'b1);
        prod(0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        prod(0, 8'hFF, 8'hFF, 1'b0, 1'b1);
        in_valid[0] = 1'b0;
        drain(0);
`endif

        // MUL_LAT=1 instance: acc_clr=0 on repeats accumulates only in MAC builds.
        t1.delete();
        prod(1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        prod(1, 8'hFF, 8'hFF, 1'b0, 1'b1);
        prod(1, 8'h03, 8'h04, 1'b0, 1'b1);
        in_valid[1] = 1'b0;
        drain(1);
        chk("stream_count_l1", 32'(t1.size()), 32'd3);
        if (t1.size() == 3) begin
            chk("stream_period_l1_a", 32'(t1[1] - t1[0]), 32'd5);
            chk("stream_period_l1_b", 32'(t1[2] - t1[1]), 32'd5);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
